// File: rtl/led_matrix_scanner.sv
// Row-multiplexed RGB LED matrix driver: double-buffered frame, per-slot blanking,
// global PWM brightness and per-frame horizontal mirror.
module led_matrix_scanner #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DIV  = 1000,
    parameter int BRW  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROWS*COLS*3-1:0] frame_in,
    input  logic                   load,
    input  logic                   mirror,
    input  logic [BRW-1:0]         brightness,
    output logic [ROWS-1:0]        row_en,
    output logic [COLS-1:0]        col_r,
    output logic [COLS-1:0]        col_g,
    output logic [COLS-1:0]        col_b,
    output logic                   frame_start,
    output logic                   swapped
);

    localparam int FW = ROWS * COLS * 3;
    localparam int LW = COLS * 3;
    localparam int DW = $clog2(DIV);
    localparam int RW = $clog2(ROWS);
    localparam int OW = $clog2(DIV + 1);
    localparam int PW = BRW + OW;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [FW-1:0] active_q, active_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [OW-1:0] on_len_q, on_len_d;
    logic          mirror_q, mirror_d;
    logic          swapped_q, swapped_d;

    logic          slot_end;
    logic          swap;
    logic [PW-1:0] prod;

    always_comb begin
        slot_end  = (div_cnt_q == DIV_LAST);
        swap      = slot_end && (row_q == ROW_LAST) && pending_q;

        div_cnt_d = slot_end ? '0 : div_cnt_q + DW'(1);
        row_d     = row_q;
        if (slot_end) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end

        // Full-width product so the shift sees every bit of (brightness+1)*DIV.
        prod     = (PW'(brightness) + PW'(1)) * PW'(DIV);
        on_len_d = slot_end ? OW'(prod >> BRW) : on_len_q;

        active_d  = swap ? shadow_q : active_q;
        mirror_d  = swap ? mirror   : mirror_q;
        swapped_d = swap;

        // A load on the swap cycle keeps pending set: the new frame waits a full frame.
        shadow_d  = load ? frame_in : shadow_q;
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            div_cnt_q <= '0;
            row_q     <= '0;
            on_len_q  <= '0;
            mirror_q  <= 1'b0;
            swapped_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_cnt_q <= div_cnt_d;
            row_q     <= row_d;
            on_len_q  <= on_len_d;
            mirror_q  <= mirror_d;
            swapped_q <= swapped_d;
        end
    end

    logic [LW-1:0] row_data;
    logic          lit;

    // Reset is the only input that reaches the pins: it forces them dark at once.
    always_comb begin
        row_data    = active_q[int'(row_q)*LW +: LW];
        lit         = !reset && (div_cnt_q != '0) && (OW'(div_cnt_q) < on_len_q);
        frame_start = !reset && (row_q == '0) && (div_cnt_q == '0);
        row_en      = '0;
        col_r       = '1;
        col_g       = '1;
        col_b       = '1;
        if (lit) begin
            row_en = ROWS'(1) << row_q;
            for (int c = 0; c < COLS; c++) begin
                col_r[c] = ~row_data[(mirror_q ? COLS - 1 - c : c) * 3 + 2];
                col_g[c] = ~row_data[(mirror_q ? COLS - 1 - c : c) * 3 + 1];
                col_b[c] = ~row_data[(mirror_q ? COLS - 1 - c : c) * 3];
            end
        end
    end

    assign swapped = swapped_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with an 8x8 matrix, DIV=8, BRW=3.
module tb_led_matrix_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DIV  = 8;
    localparam int BRW  = 3;
    localparam int FW   = ROWS * COLS * 3;

    logic            clk;
    logic            reset;
    logic [FW-1:0]   frame_in;
    logic            load;
    logic            mirror;
    logic [BRW-1:0]  brightness;
    logic [ROWS-1:0] row_en;
    logic [COLS-1:0] col_r, col_g, col_b;
    logic            frame_start;
    logic            swapped;

    led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BRW(BRW)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .load        (load),
        .mirror      (mirror),
        .brightness  (brightness),
        .row_en      (row_en),
        .col_r       (col_r),
        .col_g       (col_g),
        .col_b       (col_b),
        .frame_start (frame_start),
        .swapped     (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         row;
        int         div;
        logic [7:0] en;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       fs;
    } vec_t;

    int n_vec  = 0;
    int n_err  = 0;
    int sw_cnt = 0;
    int m_row  = 0;
    int m_div  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (row %0d div %0d)", nm, got, exp, m_row, m_div);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] en, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
        chk({nm, ".row_en"}, 32'(row_en), 32'(en));
        chk({nm, ".col_r"},  32'(col_r),  32'(r));
        chk({nm, ".col_g"},  32'(col_g),  32'(g));
        chk({nm, ".col_b"},  32'(col_b),  32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_row = 0;
            m_div = 0;
        end else if (m_div == DIV - 1) begin
            m_div = 0;
            m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
            m_div++;
        end
        #1;
        if (swapped) sw_cnt++;
    endtask

    task automatic goto(input int r, input int d);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(m_row == r && m_div == d) && k <= ROWS * DIV);
        if (!(m_row == r && m_div == d)) begin
            n_err++;
            $display("FAIL goto: reached row %0d div %0d, required row %0d div %0d", m_row, m_div, r, d);
        end
    endtask

    task automatic wait_swapped(input string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!swapped && k <= ROWS * DIV + 2);
        chk({nm, ".swapped"}, 32'(swapped), 32'd1);
        chk({nm, ".frame_start"}, 32'(frame_start), 32'd1);
    endtask

    vec_t tbl[8];
    logic [FW-1:0] fa, fb, fc;
    int sw0;

    initial begin
        fa = '0;
        fa[3*24 +: 24] = 24'hFFFE00;
        fa[2*24 +: 24] = 24'hB6DB6D;
        fb = '0;
        fb[23:0] = 24'hFFFFFF;
        fc = '0;
        fc[5*24 +: 24] = 24'h000004;

        tbl[0] = '{0, 3, 8'h01, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[1] = '{2, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[2] = '{2, 1, 8'h04, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[3] = '{2, 7, 8'h04, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{3, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[5] = '{3, 4, 8'h08, 8'h07, 8'h07, 8'h07, 1'b0};
        tbl[6] = '{7, 7, 8'h80, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[7] = '{0, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1};

        reset      = 1'b1;
        load       = 1'b0;
        mirror     = 1'b0;
        brightness = 3'd7;
        frame_in   = '0;

        // Reset state and release
        tick();
        tick();
        chk_out("rst", 8'h00, 8'hFF, 8'hFF, 8'hFF);
        chk("rst.frame_start", 32'(frame_start), 32'd0);
        chk("rst.swapped", 32'(swapped), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel.frame_start", 32'(frame_start), 32'd1);
        chk("rel.row_en", 32'(row_en), 32'd0);

        // First frame load and row/column mapping
        load = 1'b1;
        frame_in = fa;
        tick();
        load = 1'b0;
        wait_swapped("swap_a");
        for (int i = 0; i < 8; i++) begin
            goto(tbl[i].row, tbl[i].div);
            chk_out($sformatf("map%0d", i), tbl[i].en, tbl[i].r, tbl[i].g, tbl[i].b);
            chk($sformatf("map%0d.frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
        end

        // Mirror applied at the swap; later toggles without a swap have no effect
        goto(0, 2);
        mirror = 1'b1;
        load = 1'b1;
        frame_in = fa;
        tick();
        load = 1'b0;
        wait_swapped("swap_mir");
        mirror = 1'b0;
        goto(3, 2);
        chk_out("mir", 8'h08, 8'hE0, 8'hE0, 8'hE0);
        sw0 = sw_cnt;
        goto(3, 2);
        chk_out("mir_hold", 8'h08, 8'hE0, 8'hE0, 8'hE0);
        chk("mir_hold.swaps", 32'(sw_cnt - sw0), 32'd0);

        // Brightness changes land at the next slot boundary
        goto(4, 3);
        brightness = 3'd3;
        goto(4, 5);
        chk("bri_midslot.row_en", 32'(row_en), 32'h10);
        goto(5, 1);
        chk("bri3_d1.row_en", 32'(row_en), 32'h20);
        goto(5, 3);
        chk("bri3_d3.row_en", 32'(row_en), 32'h20);
        goto(5, 4);
        chk("bri3_d4.row_en", 32'(row_en), 32'h00);
        goto(5, 7);
        chk("bri3_d7.row_en", 32'(row_en), 32'h00);
        brightness = 3'd0;
        goto(6, 1);
        chk("bri0_d1.row_en", 32'(row_en), 32'h00);
        goto(6, 5);
        chk("bri0_d5.row_en", 32'(row_en), 32'h00);
        brightness = 3'd7;
        goto(7, 1);
        chk("bri7_d1.row_en", 32'(row_en), 32'h80);

        // Two loads in one frame: last wins, single swap at the row 0 boundary
        goto(0, 1);
        load = 1'b1;
        frame_in = fb;
        tick();
        load = 1'b0;
        goto(2, 0);
        load = 1'b1;
        frame_in = fc;
        tick();
        load = 1'b0;
        sw0 = sw_cnt;
        wait_swapped("swap_last");
        goto(0, 2);
        chk_out("last_r0", 8'h01, 8'hFF, 8'hFF, 8'hFF);
        goto(5, 1);
        chk_out("last_r5", 8'h20, 8'hFE, 8'hFF, 8'hFF);
        goto(0, 2);
        chk("last.swaps", 32'(sw_cnt - sw0), 32'd1);

        // Load on the swap cycle: old shadow now, new frame one frame later
        goto(1, 0);
        load = 1'b1;
        frame_in = fa;
        tick();
        load = 1'b0;
        goto(7, 7);
        load = 1'b1;
        frame_in = fb;
        tick();
        load = 1'b0;
        chk("los.swapped", 32'(swapped), 32'd1);
        goto(3, 4);
        chk_out("los_old", 8'h08, 8'h07, 8'h07, 8'h07);
        wait_swapped("swap_los");
        goto(0, 3);
        chk_out("los_new_r0", 8'h01, 8'h00, 8'h00, 8'h00);
        goto(3, 4);
        chk_out("los_new_r3", 8'h08, 8'hFF, 8'hFF, 8'hFF);

        // No load: frame repeats, no swap
        sw0 = sw_cnt;
        goto(3, 4);
        chk("rep.swaps", 32'(sw_cnt - sw0), 32'd0);
        goto(0, 3);
        chk_out("rep_r0", 8'h01, 8'h00, 8'h00, 8'h00);

        // Reset mid-scan with a pending frame
        load = 1'b1;
        frame_in = fc;
        tick();
        load = 1'b0;
        goto(4, 3);
        reset = 1'b1;
        #1;
        chk_out("rst_mid_now", 8'h00, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("rst_mid%0d", i), 8'h00, 8'hFF, 8'hFF, 8'hFF);
            chk($sformatf("rst_mid%0d.swapped", i), 32'(swapped), 32'd0);
            chk($sformatf("rst_mid%0d.frame_start", i), 32'(frame_start), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("rel2.frame_start", 32'(frame_start), 32'd1);
        chk("rel2.row_en", 32'(row_en), 32'd0);
        sw0 = sw_cnt;
        goto(0, 3);
        chk("rel2_slot0.row_en", 32'(row_en), 32'd0);
        goto(5, 1);
        chk_out("rel2_r5", 8'h20, 8'hFF, 8'hFF, 8'hFF);
        goto(0, 3);
        chk_out("rel2_r0", 8'h01, 8'hFF, 8'hFF, 8'hFF);
        chk("rel2.swaps", 32'(sw_cnt - sw0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
